// File: rtl/qed_dup_ctrl.sv
// QED mode sequencer: counts originals, flips the QED block into duplicate mode,
// counts replayed duplicates and pulses qed_check when a full block has issued.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_ORIG  | accepting originals from fetch, exec_dup=0
// ST_DUP   | replaying duplicates from the QED i-cache, exec_dup=1
// ST_CHECK | one-cycle block-complete pulse, counters still show the block
module qed_dup_ctrl #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             stall_IF,
   input  logic             inst_vld,
   input  logic             dup_vld,
   input  logic             force_dup,
   output logic             exec_dup,
   output logic             qed_check,
   output logic [CNT_W-1:0] orig_cnt,
   output logic [CNT_W-1:0] dup_cnt,
   output logic             err
);

   typedef enum logic [1:0] {
      ST_ORIG  = 2'd0,
      ST_DUP   = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] orig_cnt_q, orig_cnt_d;
   logic [CNT_W-1:0] dup_cnt_q, dup_cnt_d;
   logic [CNT_W-1:0] orig_inc, dup_inc;
   logic             exec_dup_q, exec_dup_d;
   logic             qed_check_q, qed_check_d;
   logic             err_q, err_d;
   logic             orig_acc, dup_acc;

   always_comb begin
      orig_acc    = (state_q == ST_ORIG) && ena && inst_vld && !stall_IF;
      dup_acc     = (state_q == ST_DUP) && dup_vld && !stall_IF;
      orig_inc    = orig_cnt_q + {{(CNT_W-1){1'b0}}, orig_acc};
      dup_inc     = dup_cnt_q + {{(CNT_W-1){1'b0}}, dup_acc};
      state_d     = state_q;
      orig_cnt_d  = orig_cnt_q;
      dup_cnt_d   = dup_cnt_q;
      err_d       = err_q;
      unique case (state_q)
         ST_ORIG: begin
            orig_cnt_d = orig_inc;
            // a stalled fetch freezes the block, including an early close request
            if (!stall_IF && ((orig_inc == CNT_W'(DEPTH)) ||
                              (force_dup && ena && (orig_inc != '0))))
               state_d = ST_DUP;
         end
         ST_DUP: begin
            dup_cnt_d = dup_inc;
            if (dup_acc && (dup_inc == orig_cnt_q))
               state_d = ST_CHECK;
            if (!dup_vld && !stall_IF)
               err_d = 1'b1;
         end
         ST_CHECK: begin
            state_d    = ST_ORIG;
            orig_cnt_d = '0;
            dup_cnt_d  = '0;
         end
         default: begin
            state_d    = ST_ORIG;
            orig_cnt_d = '0;
            dup_cnt_d  = '0;
         end
      endcase
      exec_dup_d  = (state_d == ST_DUP);
      qed_check_d = (state_d == ST_CHECK);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ORIG;
         orig_cnt_q  <= '0;
         dup_cnt_q   <= '0;
         exec_dup_q  <= 1'b0;
         qed_check_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         orig_cnt_q  <= orig_cnt_d;
         dup_cnt_q   <= dup_cnt_d;
         exec_dup_q  <= exec_dup_d;
         qed_check_q <= qed_check_d;
         err_q       <= err_d;
      end
   end

   assign exec_dup  = exec_dup_q;
   assign qed_check = qed_check_q;
   assign orig_cnt  = orig_cnt_q;
   assign dup_cnt   = dup_cnt_q;
   assign err       = err_q;

endmodule

// File: tb/tb_qed_dup_ctrl.sv
// Bench for qed_dup_ctrl: directed block scenarios plus random traffic, scored
// cycle by cycle against a behavioural model through an expectation queue.
module tb_qed_dup_ctrl;

   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic             clk_sys;
   logic             rst, ena, stall_IF, inst_vld, dup_vld, force_dup;
   logic             exec_dup, qed_check, err;
   logic [CNT_W-1:0] orig_cnt, dup_cnt;

   typedef struct {
      int exec_dup;
      int qed_check;
      int orig_cnt;
      int dup_cnt;
      int err;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // behavioural model state: 0=orig 1=dup 2=check
   int m_state = 0;
   int m_oc = 0;
   int m_dc = 0;
   int m_err = 0;

   qed_dup_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
      .clk       (clk_sys),
      .rst       (rst),
      .ena       (ena),
      .stall_IF  (stall_IF),
      .inst_vld  (inst_vld),
      .dup_vld   (dup_vld),
      .force_dup (force_dup),
      .exec_dup  (exec_dup),
      .qed_check (qed_check),
      .orig_cnt  (orig_cnt),
      .dup_cnt   (dup_cnt),
      .err       (err)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp_v, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit e, input bit s, input bit iv,
                             input bit dv, input bit fd);
      exp_t x;
      if (r) begin
         m_state = 0; m_oc = 0; m_dc = 0; m_err = 0;
      end else if (m_state == 0) begin
         if (e && iv && !s) m_oc = m_oc + 1;
         if (!s && (m_oc == DEPTH || (fd && e && m_oc != 0))) m_state = 1;
      end else if (m_state == 1) begin
         if (!s) begin
            if (dv) begin
               m_dc = m_dc + 1;
               if (m_dc == m_oc) m_state = 2;
            end else begin
               m_err = 1;
            end
         end
      end else begin
         m_state = 0; m_oc = 0; m_dc = 0;
      end
      x.exec_dup  = (m_state == 1) ? 1 : 0;
      x.qed_check = (m_state == 2) ? 1 : 0;
      x.orig_cnt  = m_oc;
      x.dup_cnt   = m_dc;
      x.err       = m_err;
      exp_q.push_back(x);
   endtask

   task automatic step(input bit r, input bit e, input bit s, input bit iv,
                       input bit dv, input bit fd);
      exp_t x;
      rst = r; ena = e; stall_IF = s; inst_vld = iv; dup_vld = dv; force_dup = fd;
      model_step(r, e, s, iv, dv, fd);
      @(posedge clk_sys);
      #1;
      if (exp_q.size() == 0) begin
         chk("sb_empty", 0, 1);
      end else begin
         x = exp_q.pop_front();
         chk("exec_dup", int'(exec_dup), x.exec_dup);
         chk("qed_check", int'(qed_check), x.qed_check);
         chk("orig_cnt", int'(orig_cnt), x.orig_cnt);
         chk("dup_cnt", int'(dup_cnt), x.dup_cnt);
         chk("err", int'(err), x.err);
      end
   endtask

   task automatic orig_n(input int n);
      for (int i = 0; i < n; i++) step(0, 1, 0, 1, 0, 0);
   endtask

   task automatic dup_n(input int n);
      for (int i = 0; i < n; i++) step(0, 1, 0, 0, 1, 0);
   endtask

   task automatic idle();
      step(0, 1, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; ena = 1'b0; stall_IF = 1'b0; inst_vld = 1'b0; dup_vld = 1'b0;
      force_dup = 1'b0;
      #1;
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 1, 1, 1);
      chk("reset_exec", int'(exec_dup), 0);
      chk("reset_orig", int'(orig_cnt), 0);

      // full block
      orig_n(DEPTH);
      chk("t1_exec_up", int'(exec_dup), 1);
      dup_n(DEPTH);
      chk("t1_check", int'(qed_check), 1);
      chk("t1_orig4", int'(orig_cnt), 4);
      chk("t1_dup4", int'(dup_cnt), 4);
      idle();
      chk("t1_after_exec", int'(exec_dup), 0);
      chk("t1_after_cnt", int'(orig_cnt), 0);

      // early close coincident with an accept
      orig_n(2);
      step(0, 1, 0, 1, 0, 1);
      chk("t2_orig3", int'(orig_cnt), 3);
      chk("t2_exec", int'(exec_dup), 1);
      dup_n(2);
      chk("t2_no_check_yet", int'(qed_check), 0);
      dup_n(1);
      chk("t2_check", int'(qed_check), 1);
      idle();

      // force on an empty block is ignored
      step(0, 1, 0, 0, 0, 1);
      chk("t3_exec", int'(exec_dup), 0);
      idle();

      // stalls inside DUP
      orig_n(DEPTH);
      dup_n(2);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
      chk("t4_dup_hold", int'(dup_cnt), 2);
      chk("t4_exec_hold", int'(exec_dup), 1);
      chk("t4_err_clean", int'(err), 0);
      dup_n(1);
      chk("t4_not_yet", int'(qed_check), 0);
      dup_n(1);
      chk("t4_check", int'(qed_check), 1);
      idle();

      // missing duplicate then reset mid-DUP
      orig_n(2);
      step(0, 1, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0);
      chk("t5_err_set", int'(err), 1);
      dup_n(1);
      chk("t5_err_sticky", int'(err), 1);
      step(1, 1, 0, 0, 1, 0);
      chk("t5_rst_exec", int'(exec_dup), 0);
      chk("t5_rst_err", int'(err), 0);
      chk("t5_rst_dup", int'(dup_cnt), 0);
      chk("t5_rst_check", int'(qed_check), 0);

      // reset landing during CHECK
      orig_n(1);
      step(0, 1, 0, 0, 0, 1);
      dup_n(1);
      chk("t5b_check", int'(qed_check), 1);
      step(1, 1, 0, 0, 0, 0);
      chk("t5b_rst_check", int'(qed_check), 0);

      // ena low holds a partial block
      orig_n(2);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 1);
      chk("t6_hold", int'(orig_cnt), 2);
      orig_n(1);
      chk("t6_resume", int'(orig_cnt), 3);
      orig_n(1);
      chk("t6_full_exec", int'(exec_dup), 1);
      dup_n(DEPTH);
      chk("t6_check", int'(qed_check), 1);
      idle();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) != 0),
              ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
              ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0));
      end

      chk("sb_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
